// File: rtl/mig_maj_seq_if.sv
// mig_maj_seq_if
//   Bundles the host-side program/register access, the run handshake and the
//   shared MAJ3 array connection of the mig_maj_seq sequencer.
//   Host side : prog_we/prog_addr/prog_data   program memory write
//               reg_we/reg_addr/reg_wdata     register file write
//               rd_addr -> rd_data            combinational register read
//               start/len -> busy/done        run control
//   Array side: maj_a/maj_b/maj_c/maj_valid -> maj_y (same-cycle result)
//   Modports  : slave  = the sequencer, master = host plus MAJ3 array.
interface mig_maj_seq_if #(
  parameter int W     = 32,
  parameter int NREG  = 16,
  parameter int NPROG = 32
);
  localparam int R  = $clog2(NREG);
  localparam int P  = $clog2(NPROG);
  localparam int IW = 4 * R + 4;

  logic          prog_we;
  logic [P-1:0]  prog_addr;
  logic [IW-1:0] prog_data;
  logic          reg_we;
  logic [R-1:0]  reg_addr;
  logic [W-1:0]  reg_wdata;
  logic [R-1:0]  rd_addr;
  logic [W-1:0]  rd_data;
  logic          start;
  logic [P:0]    len;
  logic          busy;
  logic          done;
  logic [W-1:0]  maj_a;
  logic [W-1:0]  maj_b;
  logic [W-1:0]  maj_c;
  logic          maj_valid;
  logic [W-1:0]  maj_y;

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  reg_we, reg_addr, reg_wdata,
    input  rd_addr,
    output rd_data,
    input  start, len,
    output busy, done,
    output maj_a, maj_b, maj_c, maj_valid,
    input  maj_y
  );

  modport master (
    output prog_we, prog_addr, prog_data,
    output reg_we, reg_addr, reg_wdata,
    output rd_addr,
    input  rd_data,
    output start, len,
    input  busy, done,
    input  maj_a, maj_b, maj_c, maj_valid,
    output maj_y
  );
endinterface

// File: rtl/mig_maj_seq.sv
// mig_maj_seq
//   Microprogram sequencer that walks a list of majority-inverter graph nodes
//   and time-multiplexes one external W-bit bitwise MAJ3 array across them.
//   Each node takes three cycles: FETCH (read operands with optional
//   complement), EXEC (array evaluates, result optionally complemented),
//   WB (result written to the destination register).
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset (memories are not cleared)
//     bus  mig_maj_seq_if.slave: program/register load, register readback,
//          start/len/busy/done handshake and the MAJ3 array operands/result.
//   Instruction word (LSB first): c, ic, b, ib, a, ia, dst, inv_out,
//   each register field R = $clog2(NREG) bits wide.
module mig_maj_seq #(
  parameter int W     = 32,
  parameter int NREG  = 16,
  parameter int NPROG = 32
) (
  input logic          clk,
  input logic          rst,
  mig_maj_seq_if.slave bus
);
  localparam int R  = $clog2(NREG);
  localparam int P  = $clog2(NPROG);
  localparam int IW = 4 * R + 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [P-1:0]  pc;
  logic [P:0]    len_q;
  logic [R-1:0]  dst_q;
  logic          inv_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  maj_a_q;
  logic [W-1:0]  maj_b_q;
  logic [W-1:0]  maj_c_q;
  logic          busy;
  logic          done;
  logic          maj_valid;

  logic [IW-1:0] prog_mem [NPROG];
  logic [W-1:0]  regfile  [NREG];

  logic [IW-1:0] instr;
  logic [R-1:0]  f_c, f_b, f_a, f_dst;
  logic          f_ic, f_ib, f_ia, f_inv;
  logic [P:0]    len_clamped;
  logic          last_instr;

  assign instr = prog_mem[pc];
  assign f_c   = instr[R-1:0];
  assign f_ic  = instr[R];
  assign f_b   = instr[2*R:R+1];
  assign f_ib  = instr[2*R+1];
  assign f_a   = instr[3*R+1:2*R+2];
  assign f_ia  = instr[3*R+2];
  assign f_dst = instr[4*R+2:3*R+3];
  assign f_inv = instr[4*R+3];

  assign len_clamped = (bus.len > (P+1)'(NPROG)) ? (P+1)'(NPROG) : bus.len;
  // pc is zero-extended so a full program (len == NPROG) ends at pc == NPROG-1.
  assign last_instr  = ({1'b0, pc} == (len_q - (P+1)'(1)));

  // Next-state and control outputs; control outputs decode straight from the
  // state so an asynchronous reset drops them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    maj_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (len_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        maj_valid = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        state_nxt = last_instr ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      len_q   <= '0;
      dst_q   <= '0;
      inv_q   <= 1'b0;
      res_q   <= '0;
      maj_a_q <= '0;
      maj_b_q <= '0;
      maj_c_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q <= len_clamped;
            pc    <= '0;
          end
        end
        FETCH: begin
          maj_a_q <= regfile[f_a] ^ {W{f_ia}};
          maj_b_q <= regfile[f_b] ^ {W{f_ib}};
          maj_c_q <= regfile[f_c] ^ {W{f_ic}};
          dst_q   <= f_dst;
          inv_q   <= f_inv;
        end
        EXEC: begin
          res_q <= bus.maj_y ^ {W{inv_q}};
        end
        WB: begin
          if (!last_instr) begin
            pc <= pc + P'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memories are deliberately outside the reset domain. WB and host writes
  // never collide because host writes are only honoured while not busy.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy) begin
      prog_mem[bus.prog_addr] <= bus.prog_data;
    end
    if (state == WB) begin
      regfile[dst_q] <= res_q;
    end else if (bus.reg_we && !busy) begin
      regfile[bus.reg_addr] <= bus.reg_wdata;
    end
  end

  assign bus.rd_data   = regfile[bus.rd_addr];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.maj_valid = maj_valid;
  assign bus.maj_a     = maj_a_q;
  assign bus.maj_b     = maj_b_q;
  assign bus.maj_c     = maj_c_q;
endmodule

// File: tb/tb_mig_maj_seq.sv
// tb_mig_maj_seq
//   Directed bench for mig_maj_seq. The bench plays the host and the external
//   bitwise MAJ3 array; expected register contents and cycle counts are
//   hand-computed constants.
module tb_mig_maj_seq;
  localparam int W     = 32;
  localparam int NREG  = 16;
  localparam int NPROG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  mig_maj_seq_if #(.W(W), .NREG(NREG), .NPROG(NPROG)) bus ();

  assign bus.maj_y = (bus.maj_a & bus.maj_b) | (bus.maj_a & bus.maj_c) |
                     (bus.maj_b & bus.maj_c);

  mig_maj_seq #(.W(W), .NREG(NREG), .NPROG(NPROG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Field order MSB..LSB: inv_out, dst, ia, a, ib, b, ic, c
  function automatic logic [19:0] enc(input logic [3:0] dst, input logic inv,
                                      input logic [3:0] a, input logic ia,
                                      input logic [3:0] b, input logic ib,
                                      input logic [3:0] c, input logic ic);
    return {inv, dst, ia, a, ib, b, ic, c};
  endfunction

  task automatic writeReg(input logic [3:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    @(negedge clk);
    bus.reg_we    = 1'b0;
  endtask

  task automatic writeProg(input logic [4:0] addr, input logic [19:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [3:0] addr,
                          input logic [W-1:0] exp);
    bus.rd_addr = addr;
    #1;
    checkOutput(tag, bus.rd_data, exp);
  endtask

  // Starts a run of n instructions and counts negedges until done. disturb
  // injects start/reg_we/prog_we pulses mid-run; rst_cycle > 0 asserts reset
  // at that cycle instead of waiting for done.
  task automatic applyStimulus(input string tag, input int n, input bit disturb,
                               input int rst_cycle, input int exp_cycles,
                               input int exp_valid, input int exp_vfirst);
    int  cycles;
    int  vcnt;
    int  vfirst;
    bit  got_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 6'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles    = 0;
    vcnt      = 0;
    vfirst    = 0;
    got_done  = 1'b0;
    while (!got_done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bus.maj_valid) begin
        vcnt++;
        if (vfirst == 0) vfirst = cycles;
      end
      if (bus.done) got_done = 1'b1;
      if (disturb && cycles == 4) begin
        bus.start     = 1'b1;
        bus.len       = 6'd1;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 4'd1;
        bus.reg_wdata = 32'hFFFF0000;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd2;
        bus.prog_data = enc(4'd12, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0);
      end
      if (disturb && cycles == 5) begin
        bus.start   = 1'b0;
        bus.reg_we  = 1'b0;
        bus.prog_we = 1'b0;
      end
      if (rst_cycle != 0 && cycles == rst_cycle) begin
        checkOutput({tag, "_pre_rst_valid"}, 32'(bus.maj_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_rst_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_rst_valid"}, 32'(bus.maj_valid), 32'd0);
        checkOutput({tag, "_rst_maj_a"}, bus.maj_a, 32'd0);
        checkOutput({tag, "_rst_maj_b"}, bus.maj_b, 32'd0);
        checkOutput({tag, "_rst_maj_c"}, bus.maj_c, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    checkOutput({tag, "_valid_cnt"}, 32'(vcnt), 32'(exp_valid));
    if (exp_valid > 0) begin
      checkOutput({tag, "_valid_first"}, 32'(vfirst), 32'(exp_vfirst));
    end
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.rd_addr   = '0;
    bus.start     = 1'b0;
    bus.len       = '0;
    #2;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_valid", 32'(bus.maj_valid), 32'd0);
    checkOutput("reset_maj_a", bus.maj_a, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic MAJ");
    writeReg(4'd1, 32'h00000F0F);
    writeReg(4'd2, 32'h000000FF);
    writeReg(4'd3, 32'h00003333);
    writeProg(5'd0, enc(4'd4, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0));
    applyStimulus("basic", 1, 1'b0, 0, 4, 1, 2);
    checkReg("basic_r4", 4'd4, 32'h0000033F);

    $display("[TB] OR/AND via constant");
    writeReg(4'd0, 32'h00000000);
    writeProg(5'd0, enc(4'd5, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b1));
    writeProg(5'd1, enc(4'd6, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0));
    applyStimulus("orand", 2, 1'b0, 0, 7, 2, 2);
    checkReg("orand_r5", 4'd5, 32'h00000FFF);
    checkReg("orand_r6", 4'd6, 32'h0000000F);

    $display("[TB] output invert and chaining");
    writeProg(5'd0, enc(4'd4, 1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0));
    writeProg(5'd1, enc(4'd7, 1'b0, 4'd4, 1'b1, 4'd4, 1'b0, 4'd4, 1'b0));
    applyStimulus("inv", 2, 1'b0, 0, 7, 2, 2);
    checkReg("inv_r4", 4'd4, 32'hFFFFFCC0);
    checkReg("inv_r7", 4'd7, 32'hFFFFFCC0);

    $display("[TB] len zero");
    applyStimulus("len0", 0, 1'b0, 0, 1, 0, 0);

    $display("[TB] busy lockout and self-source");
    writeReg(4'd8, 32'h12345678);
    writeReg(4'd12, 32'hAAAA5555);
    writeProg(5'd0, enc(4'd8, 1'b0, 4'd8, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0));
    writeProg(5'd1, enc(4'd10, 1'b0, 4'd8, 1'b0, 4'd8, 1'b0, 4'd8, 1'b0));
    writeProg(5'd2, enc(4'd11, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b1));
    applyStimulus("lock", 3, 1'b1, 0, 10, 3, 2);
    checkReg("lock_r8", 4'd8, 32'hEDCBA987);
    checkReg("lock_r10", 4'd10, 32'hEDCBA987);
    checkReg("lock_r11", 4'd11, 32'h00000FFF);
    checkReg("lock_r1", 4'd1, 32'h00000F0F);
    checkReg("lock_r12", 4'd12, 32'hAAAA5555);

    $display("[TB] async reset mid-run");
    writeReg(4'd13, 32'h11111111);
    writeReg(4'd14, 32'h22222222);
    writeProg(5'd0, enc(4'd13, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0));
    writeProg(5'd1, enc(4'd14, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 1'b1));
    writeProg(5'd2, enc(4'd15, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0));
    applyStimulus("rst", 3, 1'b0, 5, 0, 0, 0);
    checkReg("rst_r13", 4'd13, 32'h0000033F);
    checkReg("rst_r14", 4'd14, 32'h22222222);
    applyStimulus("rerun", 3, 1'b0, 0, 10, 3, 2);
    checkReg("rerun_r13", 4'd13, 32'h0000033F);
    checkReg("rerun_r14", 4'd14, 32'h00000FFF);
    checkReg("rerun_r15", 4'd15, 32'h00000F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/mig_maj_seq.md
Name: mig_maj_seq

Overview:
- Microprogram sequencer that time-multiplexes one shared W-bit bitwise MAJ3 array across a list of majority-inverter graph nodes.
- Holds a small program memory of node instructions and a register file of W-bit operands.
- For each node, it fetches operands with optional complement, drives the external MAJ3 array, optionally complements the result and writes it back.
- Sits between the host/bus side (program load, operand load, result readback) and the gate-level MAJ3 datapath.

Parameters:
- W, 32, data width of operands and of the MAJ3 array.
- NREG, 16, number of registers; R = $clog2(NREG).
- NPROG, 32, number of instruction slots; P = $clog2(NPROG).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  P  program write address.
- prog_data  in  4R+4  instruction word.
- reg_we  in  1  host register write strobe.
- reg_addr  in  R  host register write address.
- reg_wdata  in  W  host register write data.
- rd_addr  in  R  host read address.
- rd_data  out  W  combinational regfile[rd_addr].
- start  in  1  begin execution of instructions 0..len-1.
- len  in  P+1  instruction count, 0..NPROG.
- busy  out  1  high from FETCH through WB.
- done  out  1  one-cycle completion pulse.
- maj_a, maj_b, maj_c  out  W  operands to the shared MAJ3 array.
- maj_valid  out  1  high in EXEC only.
- maj_y  in  W  combinational MAJ3 result, same cycle.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values: busy=0, done=0, maj_valid=0, maj_a/b/c=0, pc=0, state=IDLE.
- Reset does not clear the program memory or the register file. Their contents are undefined until written.
- Instruction fields:
  - c = [R-1:0], ic = [R]
  - b = [2R:R+1], ib = [2R+1]
  - a = [3R+1:2R+2], ia = [3R+2]
  - dst = [4R+2:3R+3], inv_out = [4R+3]
- States:
  - IDLE: on start with len>0, latch len and set pc=0, go to FETCH. On start with len==0, go to DONE.
  - FETCH: read prog[pc] combinationally. At the clock edge, load maj_a = regfile[a] ^ {W{ia}}, and likewise maj_b with b/ib and maj_c with c/ic. Latch dst and inv_out. Go to EXEC.
  - EXEC: maj_valid=1. At the clock edge, capture res = maj_y ^ {W{inv_out}}. Go to WB.
  - WB: at the clock edge, regfile[dst] <= res. If pc == len-1, go to DONE; else pc++ and go to FETCH.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Timing:
  - Each instruction takes 3 cycles.
  - If start is sampled at edge t, done is high in cycle t+3N+1 for N instructions.
  - With len==0, done is high in cycle t+1.
- Operands and hazards:
  - Operands are sampled in FETCH and written in WB.
  - A node may name its own dst as a source; the old value is used.
  - The next FETCH sees the value written by the previous WB, so there is no hazard.
- maj_a/b/c hold their last value outside FETCH/EXEC/WB.
- Host interaction:
  - start is ignored while busy or in DONE.
  - prog_we and reg_we are ignored while busy, with no write performed. Outside busy, both take effect at the clock edge.
  - rd_data is always valid and reflects the current regfile contents, including during execution.
- len > NPROG is clamped to NPROG.
- Reset mid-operation:
  - All control outputs drop immediately (asynchronous).
  - A write that has not yet reached the WB edge is lost.
  - Regfile entries already written are kept.

Test Plan:
- Basic MAJ (W=32):
  - Stimulus: r1=0x0F0F, r2=0x00FF, r3=0x3333; prog[0]: dst=4, a=1, b=2, c=3, all inversions 0; len=1; start.
  - Response: maj_valid high 2 cycles after start; done 4 cycles after start; rd r4 = 0x0000033F.
- OR/AND via constant:
  - Stimulus: r0=0; prog[0]: dst=5, a=1, b=2, c=0, ic=1; prog[1]: dst=6, a=1, b=2, c=0; len=2.
  - Response: r5=0x00000FFF, r6=0x0000000F; done 7 cycles after start.
- Output invert and chaining:
  - Stimulus: prog[0] as in the basic MAJ test with inv_out=1 (dst=4); prog[1]: dst=7, a=4, ia=1, b=4, c=4, ia path only.
  - Response: r4=0xFFFFFCC0; r7=maj(~r4, r4, r4)=0xFFFFFCC0.
- len==0 and busy lockout:
  - Stimulus: start with len=0.
  - Response: done pulses next cycle, no maj_valid.
  - Stimulus: during a 3-instruction run, pulse start, reg_we to r1, and prog_we.
  - Response: none take effect; results match the undisturbed run.
- Async reset mid-run:
  - Stimulus: 3-instruction program; assert rst during EXEC of instruction 1.
  - Response: busy, done, maj_valid and maj_a/b/c go to 0 without waiting for clk.
  - Response: instruction 0's dst holds its new value; instruction 1's dst is unchanged.
  - Response: a following start runs normally from pc=0.
